prog_loader: RTL and testbench

Hardware program loader; the initiator side of the CPU's instruction-initialize interface. Receives a byte stream on a valid/ready handshake, assembles big-endian address/data records, and presents each record on initialize / instruction_initialize_address / instruction_initialize_data for a fixed hold time. Holds the CPU in reset throughout loading, then releases initialize and CPU reset together.

---
 rtl/prog_loader_pkg.sv | 12 +
 rtl/prog_loader_byte_assembler.sv | 28 ++
 rtl/prog_loader.sv | 92 +++++++++
 tb/tb_prog_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: state encoding and stream framing constants for the program loader.
package prog_loader_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam int RECORD_BYTES    = 8;
    localparam int BYTES_PER_FIELD = RECORD_BYTES / 2;
    localparam int COUNT_W         = 8;
endpackage

// File: rtl/prog_loader_byte_assembler.sv
// byte_assembler: big-endian 4-byte shift register; word is valid in the cycle word_complete pulses.
module byte_assembler
    import prog_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic [7:0]                   byte_in,
    output logic [8*BYTES_PER_FIELD-1:0] word,
    output logic                         word_complete
);
    logic [8*(BYTES_PER_FIELD-1)-1:0] sh;
    logic [1:0] idx;
    assign word = {sh, byte_in};
    assign word_complete = en && idx == 2'(BYTES_PER_FIELD - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            sh  <= word[8*(BYTES_PER_FIELD-1)-1:0];
            idx <= idx + 2'd1;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams COUNT address/data records into CPU instruction memory,
// holding the CPU in reset until every record has been written.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              initialize,
    output logic [ADDR_W-1:0] instruction_initialize_address,
    output logic [DATA_W-1:0] instruction_initialize_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    logic [2:0] state, nxt;
    logic [COUNT_W-1:0] count;
    logic [HC_W-1:0] hold_cnt;
    logic [8*BYTES_PER_FIELD-1:0] addr_buf, word;
    logic xfer, in_field, wc, last_rec, hold_end, rec_done, aligned;
    assign xfer     = byte_valid && byte_ready;
    assign in_field = state == S_ADDR || state == S_DATA;
    assign last_rec = count == COUNT_W'(1);
    assign hold_end = hold_cnt == HC_W'(HOLD_CYCLES - 1);
    assign rec_done = state == S_DATA && wc;
    assign aligned  = addr_buf[1:0] == 2'b00;
    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr          (!in_field),
        .en           (xfer && in_field),
        .byte_in      (byte_in),
        .word         (word),
        .word_complete(wc)
    );
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: nxt = start ? S_HDR : state;
            S_HDR:          nxt = !xfer ? state : byte_in == 8'd0 ? S_DONE : S_ADDR;
            S_ADDR:         nxt = wc ? S_DATA : state;
            S_DATA:         nxt = !wc ? state : aligned ? S_WRITE : last_rec ? S_DONE : S_ADDR;
            S_WRITE:        nxt = !hold_end ? state : last_rec ? S_DONE : S_ADDR;
            default:        nxt = S_IDLE;
        endcase
    end
    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                          <= S_IDLE;
            count                          <= '0;
            hold_cnt                       <= '0;
            addr_buf                       <= '0;
            byte_ready                     <= 1'b0;
            initialize                     <= 1'b1;
            cpu_rst                        <= 1'b1;
            done                           <= 1'b0;
            err                            <= 1'b0;
            instruction_initialize_address <= '0;
            instruction_initialize_data    <= '0;
        end else begin
            state      <= nxt;
            byte_ready <= nxt == S_HDR || nxt == S_ADDR || nxt == S_DATA;
            initialize <= nxt != S_DONE;
            cpu_rst    <= nxt != S_DONE;
            done       <= nxt == S_DONE;
            hold_cnt   <= state == S_WRITE ? hold_cnt + HC_W'(1) : '0;
            if (state == S_HDR && xfer)
                count <= byte_in;
            else if ((rec_done && !aligned) || (state == S_WRITE && hold_end))
                count <= count - COUNT_W'(1);
            if (state == S_ADDR && wc)
                addr_buf <= word;
            if (rec_done && aligned) begin
                instruction_initialize_address <= ADDR_W'(addr_buf);
                instruction_initialize_data    <= DATA_W'(word);
            end
            if (rec_done && !aligned)
                err <= 1'b1;
            else if ((state == S_IDLE || state == S_DONE) && start)
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed stimulus checked every cycle against a record-level model.
module tb_prog_loader;
    localparam int HOLD = 2;
    localparam int P_IDLE = 0, P_HDR = 1, P_REC = 2, P_HOLD = 3, P_DONE = 4;
    logic clk = 0, rst = 0, start = 0, byte_valid = 0;
    logic [7:0] byte_in = 0;
    logic byte_ready, initialize, cpu_rst, done, err;
    logic [31:0] address, data;
    always #5 clk = ~clk;

    prog_loader #(.HOLD_CYCLES(HOLD), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .initialize(initialize),
        .instruction_initialize_address(address), .instruction_initialize_data(data),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    int n_cmp = 0, n_fail = 0;
    bit chk_en = 0;
    int ph = P_IDLE, rem = 0, k = 0, hold = 0;
    bit xf;
    logic [63:0] rec = 0;
    logic e_ready = 0, e_init = 1, e_cpu = 1, e_done = 0, e_err = 0;
    logic [31:0] e_addr = 0, e_data = 0;
    logic [63:0] wlog[$];

    task automatic m_finish();
        ph = P_DONE; e_ready = 0; e_init = 0; e_cpu = 0; e_done = 1;
    endtask

    task automatic m_next_rec();
        rem--;
        if (rem == 0) m_finish();
        else begin ph = P_REC; k = 0; e_ready = 1; end
    endtask

    // Record-level model: a session is a header byte, then records of 8 bytes, each write held HOLD cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = P_IDLE; k = 0; e_ready = 0; e_init = 1; e_cpu = 1; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
        end else begin
            xf = byte_valid && e_ready;
            case (ph)
                P_IDLE, P_DONE: if (start) begin ph = P_HDR; e_ready = 1; e_init = 1; e_cpu = 1; e_done = 0; e_err = 0; end
                P_HDR: if (xf) begin
                    rem = byte_in;
                    if (rem == 0) m_finish(); else begin ph = P_REC; k = 0; end
                end
                P_REC: if (xf) begin
                    rec = {rec[55:0], byte_in};
                    k++;
                    if (k == 8) begin
                        if (rec[33:32] == 2'b00) begin
                            e_addr = rec[63:32]; e_data = rec[31:0]; wlog.push_back(rec);
                            ph = P_HOLD; hold = HOLD; e_ready = 0;
                        end else begin
                            e_err = 1; m_next_rec();
                        end
                    end
                end
                P_HOLD: begin hold--; if (hold == 0) m_next_rec(); end
                default: ph = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ({byte_ready, initialize, cpu_rst, done, err, address, data} !==
                {e_ready, e_init, e_cpu, e_done, e_err, e_addr, e_data}) begin
                n_fail++;
                $display("FAIL cycle t=%0t got rdy=%b init=%b cpu_rst=%b done=%b err=%b addr=%h data=%h want rdy=%b init=%b cpu_rst=%b done=%b err=%b addr=%h data=%h",
                    $time, byte_ready, initialize, cpu_rst, done, err, address, data,
                    e_ready, e_init, e_cpu, e_done, e_err, e_addr, e_data);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); byte_valid = 0; start = 0; end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1; byte_valid = 0; wlog.delete();
        @(negedge clk); start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit rs);
        repeat (gap) begin
            @(negedge clk); byte_valid = 0; byte_in = 8'($urandom); start = rs && ($urandom_range(0, 3) == 0);
        end
        for (int t = 0; ; t++) begin
            @(negedge clk); start = 0; byte_valid = 1; byte_in = b;
            if (byte_ready) break;
            if (t == 60) begin n_fail++; $display("FAIL send_timeout byte=%h never accepted", b); break; end
        end
    endtask

    task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input int gap, input bit rs);
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], gap, rs);
        for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8], gap, rs);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", {58'd0, byte_ready, initialize, cpu_rst, done, err, |address}, {58'd0, 6'b011000});
        rst = 1; chk_en = 1;

        // 1: single SUB record, exact hold window and release edge
        pulse_start();
        send_byte(8'd1, 0, 0);
        send_rec(32'h0, 32'h00044022, 0, 0);
        idle(1);
        chk("s1_addr", address, 32'h0);
        chk("s1_data", data, 32'h00044022);
        chk("s1_hold1", {byte_ready, initialize, done}, 3'b010);
        idle(1);
        chk("s1_hold2", {byte_ready, initialize, done}, 3'b010);
        idle(1);
        chk("s1_release", {initialize, cpu_rst, done}, 3'b001);

        // 2: three records
        pulse_start();
        send_byte(8'd3, 0, 0);
        send_rec(32'h0, 32'h0100202A, 0, 0);
        send_rec(32'h20, 32'h3C090009, 0, 0);
        send_rec(32'h28, 32'h1000FFFF, 0, 0);
        idle(HOLD + 2);
        chk("s2_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("s2_w0", wlog[0], {32'h0, 32'h0100202A});
            chk("s2_w1", wlog[1], {32'h20, 32'h3C090009});
            chk("s2_w2", wlog[2], {32'h28, 32'h1000FFFF});
        end
        chk("s2_done", {done, cpu_rst}, 2'b10);

        // 3: misaligned record skipped, err sticky
        pulse_start();
        chk("s3_err_cleared", err, 0);
        send_byte(8'd2, 0, 0);
        send_rec(32'h06, 32'hDEADBEEF, 0, 0);
        send_rec(32'h04, 32'h0, 0, 0);
        idle(HOLD + 2);
        chk("s3_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) chk("s3_w0", wlog[0], {32'h4, 32'h0});
        chk("s3_err_done", {err, done}, 2'b11);

        // 4: empty program
        pulse_start();
        send_byte(8'd0, 0, 0);
        idle(1);
        chk("s4_done", {initialize, cpu_rst, done, err}, 4'b0010);
        chk("s4_nwrites", wlog.size(), 0);

        // 5: byte_valid toggled every other cycle
        pulse_start();
        send_byte(8'd1, 1, 0);
        send_rec(32'h0, 32'h00044022, 1, 0);
        idle(HOLD + 2);
        chk("s5_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) chk("s5_w0", wlog[0], {32'h0, 32'h00044022});

        // 6: reset mid-DATA, then a clean session
        pulse_start();
        send_byte(8'd1, 0, 0);
        for (int i = 0; i < 4; i++) send_byte(8'hAA, 0, 0);
        send_byte(8'h55, 0, 0);
        send_byte(8'h66, 0, 0);
        @(negedge clk); byte_valid = 0;
        #1 rst = 0;
        #1 chk("s6_async_reset", {byte_ready, initialize, cpu_rst, done, err, address, data}, {5'b01100, 64'h0});
        @(negedge clk); rst = 1;
        pulse_start();
        send_byte(8'd1, 0, 0);
        send_rec(32'h0C, 32'h08000004, 0, 0);
        idle(HOLD + 2);
        chk("s6_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) chk("s6_w0", wlog[0], {32'h0C, 32'h08000004});

        // randomized sessions: random counts, alignment, gaps and ignored start pulses
        for (int s = 0; s < 12; s++) begin
            int n;
            n = $urandom_range(0, 4);
            pulse_start();
            send_byte(8'(n), $urandom_range(0, 2), 1);
            for (int r = 0; r < n; r++) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
                send_rec(a, $urandom, $urandom_range(0, 2), 1);
            end
            idle(HOLD + 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
